// File: rtl/sorting_pkg.sv
// Shared types and sizing helpers for the packet sorter.
package sorting_pkg;

    localparam int unsigned DefaultMaxPktLen = 128;

    // Word counts run 0..MaxPktLen inclusive, hence the +1.
    localparam int unsigned IdxWidth = $clog2(DefaultMaxPktLen + 1);

    typedef enum logic [1:0] {
        StRecv,
        StSort,
        StSend
    } state_e;

    // Sub-steps of one bubble pass.
    typedef enum logic [1:0] {
        PhIssue,
        PhScan,
        PhFlush
    } sort_ph_e;

    function automatic int unsigned idx_width(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/sorting_ram.sv
// Simple dual-port packet buffer: one write port, one read port, 1-cycle registered read.
module sorting_ram #(
    parameter int unsigned DWIDTH = 64,
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned AW     = 7
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DWIDTH-1:0] rdata_o
);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [DWIDTH-1:0] rdata_q;

    // Write port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Read port; output holds its value while no read is issued.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sorting.sv
// Packet sorter: stores one Avalon-ST packet, bubble-sorts it ascending in place, re-emits it.
module sorting
    import sorting_pkg::*;
#(
    parameter int unsigned DWIDTH      = 64,
    parameter int unsigned MAX_PKT_LEN = 128
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DWIDTH-1:0] snk_data_i,
    input  logic              snk_startofpacket_i,
    input  logic              snk_endofpacket_i,
    input  logic              snk_valid_i,
    output logic              snk_ready_o,
    output logic [DWIDTH-1:0] src_data_o,
    output logic              src_startofpacket_o,
    output logic              src_endofpacket_o,
    output logic              src_valid_o,
    input  logic              src_ready_i
);

    localparam int unsigned IdxW  = idx_width(MAX_PKT_LEN);
    localparam int unsigned AddrW = (MAX_PKT_LEN > 1) ? $clog2(MAX_PKT_LEN) : 1;

    state_e            state_q, state_d;
    sort_ph_e          ph_q, ph_d;
    logic [IdxW-1:0]   count_q, count_d;
    logic              started_q, started_d;
    logic [IdxW-1:0]   pass_end_q, pass_end_d;
    logic [IdxW-1:0]   j_q, j_d;
    logic [DWIDTH-1:0] carry_q, carry_d;
    logic [IdxW-1:0]   rd_ptr_q, rd_ptr_d;
    logic              pend_q, pend_d;
    logic [IdxW-1:0]   out_idx_q, out_idx_d;
    logic [DWIDTH-1:0] out_data_q, out_data_d;
    logic              out_sop_q, out_sop_d;
    logic              out_eop_q, out_eop_d;
    logic              out_valid_q, out_valid_d;
    logic              snk_ready_q, snk_ready_d;

    logic              ram_we, ram_re;
    logic [AddrW-1:0]  ram_waddr, ram_raddr;
    logic [DWIDTH-1:0] ram_wdata, ram_rdata;
    logic              swap, load_out;

    sorting_ram #(
        .DWIDTH (DWIDTH),
        .DEPTH  (MAX_PKT_LEN),
        .AW     (AddrW)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    // Next-state, buffer access and output pipeline control.
    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        count_d     = count_q;
        started_d   = started_q;
        pass_end_d  = pass_end_q;
        j_d         = j_q;
        carry_d     = carry_q;
        rd_ptr_d    = '0;
        pend_d      = 1'b0;
        out_idx_d   = '0;
        out_data_d  = out_data_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_valid_d = 1'b0;
        ram_we      = 1'b0;
        ram_waddr   = '0;
        ram_wdata   = snk_data_i;
        ram_re      = 1'b0;
        ram_raddr   = '0;
        swap        = carry_q > ram_rdata;
        load_out    = 1'b0;

        unique case (state_q)
            StRecv: begin
                ph_d = PhIssue;
                // Beats before the first sop are dropped.
                if (snk_valid_i && snk_ready_q && (snk_startofpacket_i || started_q)) begin
                    ram_we = 1'b1;
                    if (snk_startofpacket_i) begin
                        ram_waddr = '0;
                        count_d   = IdxW'(1);
                    end else begin
                        ram_waddr = AddrW'(count_q);
                        count_d   = count_q + IdxW'(1);
                    end
                    started_d = 1'b1;
                    // A full buffer closes the packet even without eop.
                    if (snk_endofpacket_i || (count_d == IdxW'(MAX_PKT_LEN))) begin
                        state_d    = StSort;
                        started_d  = 1'b0;
                        pass_end_d = count_d - IdxW'(1);
                    end
                end
            end

            StSort: begin
                // A pass streams words through carry_q, which always holds the running max.
                unique case (ph_q)
                    PhIssue: begin
                        if (pass_end_q == '0) begin
                            state_d = StSend;
                        end else begin
                            ram_re    = 1'b1;
                            ram_raddr = '0;
                            j_d       = '0;
                            ph_d      = PhScan;
                        end
                    end
                    PhScan: begin
                        if (j_q == '0) begin
                            carry_d = ram_rdata;
                        end else begin
                            ram_we    = 1'b1;
                            ram_waddr = AddrW'(j_q - IdxW'(1));
                            ram_wdata = swap ? ram_rdata : carry_q;
                            carry_d   = swap ? carry_q : ram_rdata;
                        end
                        if (j_q == pass_end_q) begin
                            ph_d = PhFlush;
                        end else begin
                            ram_re    = 1'b1;
                            ram_raddr = AddrW'(j_q + IdxW'(1));
                            j_d       = j_q + IdxW'(1);
                        end
                    end
                    PhFlush: begin
                        ram_we    = 1'b1;
                        ram_waddr = AddrW'(pass_end_q);
                        ram_wdata = carry_q;
                        if (pass_end_q == IdxW'(1)) begin
                            state_d = StSend;
                        end else begin
                            pass_end_d = pass_end_q - IdxW'(1);
                            ram_re     = 1'b1;
                            ram_raddr  = '0;
                            j_d        = '0;
                            ph_d       = PhScan;
                        end
                    end
                    default: ph_d = PhIssue;
                endcase
            end

            StSend: begin
                rd_ptr_d    = rd_ptr_q;
                pend_d      = pend_q;
                out_idx_d   = out_idx_q;
                out_valid_d = out_valid_q;
                // RAM output register acts as a one-word prefetch stage ahead of the output reg.
                load_out = pend_q && (!out_valid_q || src_ready_i);
                if (load_out) begin
                    out_data_d  = ram_rdata;
                    out_sop_d   = (out_idx_q == '0);
                    out_eop_d   = (out_idx_q == count_q - IdxW'(1));
                    out_valid_d = 1'b1;
                    out_idx_d   = out_idx_q + IdxW'(1);
                    pend_d      = 1'b0;
                end else if (out_valid_q && src_ready_i) begin
                    out_valid_d = 1'b0;
                    out_sop_d   = 1'b0;
                    out_eop_d   = 1'b0;
                end
                if ((rd_ptr_q < count_q) && (!pend_q || load_out)) begin
                    ram_re    = 1'b1;
                    ram_raddr = AddrW'(rd_ptr_q);
                    rd_ptr_d  = rd_ptr_q + IdxW'(1);
                    pend_d    = 1'b1;
                end
                if (out_valid_q && src_ready_i && out_eop_q) begin
                    state_d = StRecv;
                end
            end

            default: state_d = StRecv;
        endcase

        snk_ready_d = (state_d == StRecv);
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StRecv;
            ph_q        <= PhIssue;
            count_q     <= '0;
            started_q   <= 1'b0;
            pass_end_q  <= '0;
            j_q         <= '0;
            carry_q     <= '0;
            rd_ptr_q    <= '0;
            pend_q      <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_valid_q <= 1'b0;
            snk_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            count_q     <= count_d;
            started_q   <= started_d;
            pass_end_q  <= pass_end_d;
            j_q         <= j_d;
            carry_q     <= carry_d;
            rd_ptr_q    <= rd_ptr_d;
            pend_q      <= pend_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_valid_q <= out_valid_d;
            snk_ready_q <= snk_ready_d;
        end
    end

    assign snk_ready_o         = snk_ready_q;
    assign src_data_o          = out_data_q;
    assign src_startofpacket_o = out_sop_q;
    assign src_endofpacket_o   = out_eop_q;
    assign src_valid_o         = out_valid_q;

endmodule

// File: tb/tb_sorting.sv
// Randomised bench for the packet sorter against a sorted-multiset reference.
module tb_sorting;

    typedef logic [63:0] word_t;

    logic  clk_i = 1'b0;
    logic  rst_ni = 1'b0;
    word_t snk_data_i = '0;
    logic  snk_startofpacket_i = 1'b0;
    logic  snk_endofpacket_i = 1'b0;
    logic  snk_valid_i = 1'b0;
    logic  snk_ready_o;
    word_t src_data_o;
    logic  src_startofpacket_o;
    logic  src_endofpacket_o;
    logic  src_valid_o;
    logic  src_ready_i = 1'b1;

    int    n_checks = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    eop_cyc = 0;
    word_t in_q[$];
    word_t exp_q[$];

    sorting #(
        .DWIDTH      (64),
        .MAX_PKT_LEN (128)
    ) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .snk_data_i          (snk_data_i),
        .snk_startofpacket_i (snk_startofpacket_i),
        .snk_endofpacket_i   (snk_endofpacket_i),
        .snk_valid_i         (snk_valid_i),
        .snk_ready_o         (snk_ready_o),
        .src_data_o          (src_data_o),
        .src_startofpacket_o (src_startofpacket_o),
        .src_endofpacket_o   (src_endofpacket_o),
        .src_valid_o         (src_valid_o),
        .src_ready_i         (src_ready_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input word_t got, input word_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic word_t rnd_word();
        int unsigned r = $urandom_range(0, 9);
        if (r == 0) return '0;
        if (r == 1) return '1;
        if (r == 2) return word_t'($urandom_range(0, 3));
        return {$urandom, $urandom};
    endfunction

    // Reference: the output is the input multiset in ascending order.
    task automatic build_exp();
        exp_q.delete();
        foreach (in_q[i]) begin
            int k = 0;
            while (k < exp_q.size() && exp_q[k] <= in_q[i]) k++;
            exp_q.insert(k, in_q[i]);
        end
    endtask

    // Entered and left at posedge+1.
    task automatic drive_beat(input word_t d, input bit sop, input bit eop, input int gap_pct);
        while (int'($urandom_range(0, 99)) < gap_pct) begin
            snk_valid_i = 1'b0;
            @(posedge clk_i);
            #1;
        end
        snk_data_i          = d;
        snk_startofpacket_i = sop;
        snk_endofpacket_i   = eop;
        snk_valid_i         = 1'b1;
        @(negedge clk_i);
        check_eq("recv_snk_ready", 64'(snk_ready_o), 64'(1));
        check_eq("recv_src_idle", 64'(src_valid_o), 64'(0));
        @(posedge clk_i);
        #1;
        snk_valid_i = 1'b0;
    endtask

    task automatic send_pkt(input int gap_pct, input bit eop_last);
        int n = in_q.size();
        for (int i = 0; i < n; i++) begin
            drive_beat(in_q[i], i == 0, eop_last && (i == n - 1), gap_pct);
        end
        eop_cyc = cyc;
        @(negedge clk_i);
        check_eq("rdy_drop", 64'(snk_ready_o), 64'(0));
        @(posedge clk_i);
        #1;
    endtask

    task automatic recv_pkt(input bit bp, input bit junk);
        int    n = exp_q.size();
        int    idx = 0;
        int    waited = 0;
        int    limit = 2 * n * n + 40 * n + 100;
        bit    seen = 1'b0;
        bit    held = 1'b0;
        word_t hd = '0;
        bit    hs = 1'b0;
        bit    he = 1'b0;
        while (idx < n && waited < limit) begin
            src_ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (junk) begin
                snk_valid_i         = 1'b1;
                snk_data_i          = rnd_word();
                snk_startofpacket_i = 1'($urandom);
                snk_endofpacket_i   = 1'($urandom);
            end
            @(negedge clk_i);
            check_eq("rdy_busy", 64'(snk_ready_o), 64'(0));
            if (held) check_eq("hold_valid", 64'(src_valid_o), 64'(1));
            if (seen && !bp) check_eq("no_bubble", 64'(src_valid_o), 64'(1));
            if (src_valid_o) begin
                if (!seen) begin
                    seen = 1'b1;
                    check_eq("latency", 64'((cyc - eop_cyc) <= 2 * n * n + 2), 64'(1));
                    check_eq("first_sop", 64'(src_startofpacket_o), 64'(1));
                end
                if (held) begin
                    check_eq("hold_data", src_data_o, hd);
                    check_eq("hold_sop", 64'(src_startofpacket_o), 64'(hs));
                    check_eq("hold_eop", 64'(src_endofpacket_o), 64'(he));
                end
                if (src_ready_i) begin
                    check_eq("data", src_data_o, exp_q[idx]);
                    check_eq("sop", 64'(src_startofpacket_o), 64'(idx == 0));
                    check_eq("eop", 64'(src_endofpacket_o), 64'(idx == n - 1));
                    idx++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hd   = src_data_o;
                    hs   = src_startofpacket_o;
                    he   = src_endofpacket_o;
                end
            end else begin
                held = 1'b0;
            end
            @(posedge clk_i);
            #1;
            snk_valid_i = 1'b0;
            waited++;
        end
        check_eq("pkt_words", 64'(idx), 64'(n));
        src_ready_i = 1'b1;
        @(negedge clk_i);
        check_eq("rdy_back", 64'(snk_ready_o), 64'(1));
        check_eq("src_idle_after", 64'(src_valid_o), 64'(0));
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_pkt(input int gap_pct, input bit bp, input bit junk);
        build_exp();
        send_pkt(gap_pct, 1'b1);
        recv_pkt(bp, junk);
    endtask

    initial begin
        // Reset values.
        @(negedge clk_i);
        check_eq("rst_snk_ready", 64'(snk_ready_o), 64'(1));
        check_eq("rst_src_valid", 64'(src_valid_o), 64'(0));
        check_eq("rst_sop", 64'(src_startofpacket_o), 64'(0));
        check_eq("rst_eop", 64'(src_endofpacket_o), 64'(0));
        check_eq("rst_data", src_data_o, 64'(0));
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Single word.
        in_q = {64'd7};
        run_pkt(0, 1'b0, 1'b0);

        // Reverse order.
        in_q.delete();
        for (int i = 10; i >= 1; i--) in_q.push_back(word_t'(i));
        run_pkt(0, 1'b0, 1'b0);

        // Already sorted, streamed without backpressure.
        in_q.delete();
        for (int i = 0; i < 10; i++) in_q.push_back(word_t'(i));
        run_pkt(0, 1'b0, 1'b0);

        // Backpressure on a short packet.
        in_q = {64'd3, 64'd1, 64'd2};
        run_pkt(0, 1'b1, 1'b0);

        // Beats before sop are dropped; a second sop restarts the packet.
        drive_beat(64'd99, 1'b0, 1'b1, 0);
        drive_beat(64'd98, 1'b0, 1'b0, 0);
        drive_beat(64'd11, 1'b1, 1'b0, 0);
        drive_beat(64'd12, 1'b0, 1'b0, 0);
        drive_beat(64'd13, 1'b0, 1'b0, 0);
        in_q = {64'd5, 64'd5, 64'd0, '1};
        run_pkt(0, 1'b0, 1'b0);

        // Full buffer without eop closes the packet.
        in_q.delete();
        for (int i = 0; i < 128; i++) in_q.push_back(rnd_word());
        build_exp();
        send_pkt(0, 1'b0);
        recv_pkt(1'b0, 1'b0);

        // Random lengths, gaps, backpressure and ignored input while busy.
        for (int p = 0; p < 6; p++) begin
            int n = int'($urandom_range(1, 128));
            in_q.delete();
            for (int i = 0; i < n; i++) in_q.push_back(rnd_word());
            run_pkt(50, p[0], p % 3 == 0);
        end

        // Reset while sorting.
        in_q.delete();
        for (int i = 0; i < 20; i++) in_q.push_back(rnd_word());
        send_pkt(0, 1'b1);
        repeat (15) @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        @(negedge clk_i);
        check_eq("midrst_src_valid", 64'(src_valid_o), 64'(0));
        check_eq("midrst_snk_ready", 64'(snk_ready_o), 64'(1));
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_eq("postrst_snk_ready", 64'(snk_ready_o), 64'(1));
        check_eq("postrst_src_valid", 64'(src_valid_o), 64'(0));
        @(posedge clk_i);
        #1;
        in_q.delete();
        for (int i = 0; i < 12; i++) in_q.push_back(rnd_word());
        run_pkt(30, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
